cache_fill_fsm: RTL

Miss-handling controller between the CPU's fetch/memory stages and the multi-cycle pipelined main memory. When the cache signals a miss, the block reads the full 16-byte block (8 words) from memory. It steers each returned word into the cache data array and writes the tag once the block is complete. fsm_busy stalls the pipeline for the whole fill.

---
 rtl/cache_fill_fsm_if.sv | 42 ++++
 rtl/cache_fill_fsm.sv | 98 +++++++++
 2 files changed

// File: rtl/cache_fill_fsm_if.sv
// Cache miss-fill bus: the fill controller is the master (consumes miss
// and memory responses, drives requests and array writes); the cache and
// memory side is the slave. Optional CACHE_FILL_PERF_EN adds counters.
interface cache_fill_fsm_if #(
    parameter int ADDR_W = 16
);
    logic              miss_detected;
    logic [ADDR_W-1:0] miss_address;
    logic              memory_data_valid;
    logic              fsm_busy;
    logic              memory_read_req;
    logic [ADDR_W-1:0] memory_address;
    logic              write_data_array;
    logic [ADDR_W-1:0] fill_word_addr;
    logic              write_tag_array;
`ifdef CACHE_FILL_PERF_EN
    logic [15:0]       miss_count;
    logic [15:0]       fill_cycles;

    modport master (
        input  miss_detected, miss_address, memory_data_valid,
        output fsm_busy, memory_read_req, memory_address, write_data_array,
               fill_word_addr, write_tag_array, miss_count, fill_cycles
    );
    modport slave (
        output miss_detected, miss_address, memory_data_valid,
        input  fsm_busy, memory_read_req, memory_address, write_data_array,
               fill_word_addr, write_tag_array, miss_count, fill_cycles
    );
`else
    modport master (
        input  miss_detected, miss_address, memory_data_valid,
        output fsm_busy, memory_read_req, memory_address, write_data_array,
               fill_word_addr, write_tag_array
    );
    modport slave (
        output miss_detected, miss_address, memory_data_valid,
        input  fsm_busy, memory_read_req, memory_address, write_data_array,
               fill_word_addr, write_tag_array
    );
`endif
endinterface

// File: rtl/cache_fill_fsm.sv
// Cache miss-fill controller: on a miss, issues WORDS pipelined word reads
// from the block base, writes each returned word into the data array in
// arrival order and pulses the tag write with the last word.
// Optional: `define CACHE_FILL_PERF_EN adds miss_count / fill_cycles.
module cache_fill_fsm #(
    parameter int ADDR_W = 16,
    parameter int WORDS  = 8
) (
    input logic              clk,
    input logic              rst,
    cache_fill_fsm_if.master bus
);
    localparam int OFF_W = $clog2(2 * WORDS);
    localparam int CNT_W = $clog2(WORDS) + 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_FILL = 1'b1;

    logic [0:0]        r_state;
    logic [CNT_W-1:0]  r_issue_cnt;
    logic [CNT_W-1:0]  r_recv_cnt;
    logic [ADDR_W-1:0] r_base;

    logic              w_busy;
    logic              w_req;
    logic              w_wr;
    logic              w_last;
    logic              w_accept;
    logic [ADDR_W-1:0] w_issue_off;
    logic [ADDR_W-1:0] w_recv_off;

    assign w_busy      = (r_state == ST_FILL);
    assign w_req       = w_busy && (r_issue_cnt < CNT_W'(WORDS));
    assign w_wr        = w_busy && bus.memory_data_valid;
    assign w_last      = w_wr && (r_recv_cnt == CNT_W'(WORDS - 1));
    // A miss is only taken from IDLE, so a held miss restarts one cycle later.
    assign w_accept    = !w_busy && bus.miss_detected;
    assign w_issue_off = ADDR_W'({r_issue_cnt, 1'b0});
    assign w_recv_off  = ADDR_W'({r_recv_cnt, 1'b0});

    // State, latched block base and request/response counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
            r_base      <= '0;
        end else if (w_accept) begin
            r_state     <= ST_FILL;
            r_base      <= {bus.miss_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
        end else if (w_busy) begin
            if (w_req) begin
                r_issue_cnt <= r_issue_cnt + CNT_W'(1);
            end
            if (w_wr) begin
                r_recv_cnt <= r_recv_cnt + CNT_W'(1);
            end
            if (w_last) begin
                r_state <= ST_IDLE;
            end
        end
    end

    // Outputs are decoded from state; addresses read 0 when not in use.
    always_comb begin
        bus.fsm_busy         = w_busy;
        bus.memory_read_req  = w_req;
        bus.memory_address   = w_req ? (r_base + w_issue_off) : '0;
        bus.write_data_array = w_wr;
        bus.fill_word_addr   = w_busy ? (r_base + w_recv_off) : '0;
        bus.write_tag_array  = w_last;
    end

`ifdef CACHE_FILL_PERF_EN
    logic [15:0] r_miss_count;
    logic [15:0] r_fill_cycles;

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_miss_count  <= '0;
            r_fill_cycles <= '0;
        end else begin
            if (w_accept && (r_miss_count != 16'hFFFF)) begin
                r_miss_count <= r_miss_count + 16'd1;
            end
            if (w_busy && (r_fill_cycles != 16'hFFFF)) begin
                r_fill_cycles <= r_fill_cycles + 16'd1;
            end
        end
    end

    assign bus.miss_count  = r_miss_count;
    assign bus.fill_cycles = r_fill_cycles;
`endif
endmodule
